// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing constants and screen-level types.
package vga_timing_gen_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Which screen the pixel generator is currently painting.
  typedef enum logic [1:0] {
    SCREEN_TITLE,
    SCREEN_PLAY,
    SCREEN_PAUSE,
    SCREEN_OVER
  } screen_state_t;

  // Per-pixel strobes carried through the delay line; hs/vs are already
  // at their pin polarity, active is 1 for a visible pixel.
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_bits_t;

endpackage

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH shift register with synchronous active-low clear.
// DEPTH=0 degenerates to a wire.
module sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] stage;

    // Shift one slot per clock; clear flushes every slot to the idle value.
    always_ff @(posedge clk) begin
      if (!clear_n) begin
        stage <= {DEPTH{RESET_VAL}};
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters plus delayed sync/blank strobes for the VGA DAC.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE  = VGA_H_VISIBLE,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_VISIBLE  = VGA_V_VISIBLE,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter int PIPE_DELAY = 1,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       active,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  // Totals must fit the 10-bit counters (<= 1024); PIPE_DELAY is 0..4.
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  // Idle contents of the delay line: sync deasserted, pixel not visible.
  localparam logic [2:0] IDLE_BITS = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [9:0] h_q, v_q;
  logic [7:0] fc_q;
  logic       h_last, v_last;
  logic       hs_win, vs_win;
  sync_bits_t raw, dly;

  assign h_last = (h_q == 10'(H_TOTAL - 1));
  assign v_last = (v_q == 10'(V_TOTAL - 1));

  // Free-running raster counters; vcount and frame_count step on the line wrap.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      h_q  <= '0;
      v_q  <= '0;
      fc_q <= '0;
    end else if (h_last) begin
      h_q <= '0;
      if (v_last) begin
        v_q  <= '0;
        fc_q <= fc_q + 8'd1;
      end else begin
        v_q <= v_q + 10'd1;
      end
    end else begin
      h_q <= h_q + 10'd1;
    end
  end

  // Undelayed strobes decoded straight from the counter registers.
  always_comb begin
    hs_win     = (h_q >= 10'(HS_START)) && (h_q < 10'(HS_END));
    vs_win     = (v_q >= 10'(VS_START)) && (v_q < 10'(VS_END));
    raw.hs     = hs_win ? SYNC_POL : ~SYNC_POL;
    raw.vs     = vs_win ? SYNC_POL : ~SYNC_POL;
    raw.active = (h_q < 10'(H_VISIBLE)) && (v_q < 10'(V_VISIBLE));
  end

  // Align sync/blank with the pixel generator's ROM read latency.
  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (IDLE_BITS)
  ) u_dly (
    .clk     (vga_clk),
    .clear_n (reset_n),
    .din     (raw),
    .dout    (dly)
  );

  assign hcount      = h_q;
  assign vcount      = v_q;
  assign active      = raw.active;
  assign vga_hs      = dly.hs;
  assign vga_vs      = dly.vs;
  assign vga_blank_n = dly.active;
  assign vga_sync_n  = 1'b0;
  assign line_start  = (h_q == '0);
  assign frame_start = (h_q == '0) && (v_q == '0);
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: four shrunk-timing instances (PIPE_DELAY 0/1/3/4)
// against a raster model with per-instance delay scoreboards, plus one
// full 640x480 instance for the first-line and reset-release checks.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6, HT = HV + HF + HS + HB;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] hc [NI];
  logic [9:0] vc [NI];
  logic       act [NI], hs_o [NI], vs_o [NI], bl [NI], sy [NI], ls [NI], fs [NI];
  logic [7:0] fcnt [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .PIPE_DELAY((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 4),
      .SYNC_POL(1'b0)
    ) u_dut (
      .vga_clk(clk), .reset_n(reset_n), .hcount(hc[g]), .vcount(vc[g]),
      .active(act[g]), .vga_hs(hs_o[g]), .vga_vs(vs_o[g]), .vga_blank_n(bl[g]),
      .vga_sync_n(sy[g]), .line_start(ls[g]), .frame_start(fs[g]),
      .frame_count(fcnt[g])
    );
  end

  logic [9:0] d_hc, d_vc;
  logic       d_act, d_hs, d_vs, d_bl, d_sy, d_ls, d_fs;
  logic [7:0] d_fc;

  vga_timing_gen u_def (
    .vga_clk(clk), .reset_n(reset_n), .hcount(d_hc), .vcount(d_vc),
    .active(d_act), .vga_hs(d_hs), .vga_vs(d_vs), .vga_blank_n(d_bl),
    .vga_sync_n(d_sy), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  int ntests = 0, nfail = 0;
  int cyc = 0, since = 0;
  int m_h = 0, m_v = 0, m_fc = 0, d_h = 0, d_v = 0;
  logic d_exp_hs = 1'b1, d_exp_vs = 1'b1, d_exp_bl = 1'b0;
  logic [2:0] sbq [NI][$];
  logic [2:0] hist0 [$];
  int vs_low1 = 0, blank1 = 0, vs_run = 0, vs_run_max = 0;
  int d_hs_low = 0, d_hs_run = 0, d_hs_run_max = 0, d_ls_cnt = 0, d_last_ls = -1;

  function automatic int dl(input int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
  endfunction

  // Expected undelayed {hs, vs, active} for the shrunk timing.
  function automatic logic [2:0] exp_u(input int h, input int v);
    logic hs_a, vs_a, a;
    hs_a = (h >= HV + HF) && (h < HV + HF + HS);
    vs_a = (v >= VV + VF) && (v < VV + VF + VS);
    a    = (h < HV) && (v < VV);
    return {~hs_a, ~vs_a, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    logic       was_rst;
    logic [2:0] u, e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      was_rst = !reset_n;
      if (was_rst) begin
        m_h = 0; m_v = 0; m_fc = 0; d_h = 0; d_v = 0; since = 0;
        d_exp_hs = 1'b1; d_exp_vs = 1'b1; d_exp_bl = 1'b0;
        for (int g = 0; g < NI; g++) begin
          sbq[g].delete();
          for (int j = 0; j < dl(g); j++) sbq[g].push_back(3'b110);
        end
      end else begin
        d_exp_hs = !(d_h >= 656 && d_h < 752);
        d_exp_vs = !(d_v >= 490 && d_v < 492);
        d_exp_bl = (d_h < 640) && (d_v < 480);
        since++;
        if (m_h == HT - 1) begin
          m_h = 0;
          if (m_v == VT - 1) begin m_v = 0; m_fc = (m_fc + 1) % 256; end
          else m_v++;
        end else m_h++;
        if (d_h == 799) begin d_h = 0; d_v = (d_v == 524) ? 0 : d_v + 1; end
        else d_h++;
      end
      #1;
      cyc++;
      u = exp_u(m_h, m_v);
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("d%0d.hcount", dl(g)), 32'(hc[g]), 32'(m_h));
        chk($sformatf("d%0d.vcount", dl(g)), 32'(vc[g]), 32'(m_v));
        sbq[g].push_back(u);
        e = sbq[g].pop_front();
        chk($sformatf("d%0d.hs_vs_blank", dl(g)), 32'({hs_o[g], vs_o[g], bl[g]}), 32'(e));
      end
      chk("d1.active", 32'(act[1]), 32'(u[0]));
      chk("d1.line_start", 32'(ls[1]), 32'(m_h == 0));
      chk("d1.frame_start", 32'(fs[1]), 32'(m_h == 0 && m_v == 0));
      chk("d1.frame_count", 32'(fcnt[1]), 32'(m_fc));
      chk("d1.sync_n", 32'(sy[1]), 32'd0);
      // PIPE_DELAY=4 output must be the PIPE_DELAY=0 output four clocks later.
      hist0.push_back({hs_o[0], vs_o[0], bl[0]});
      if (hist0.size() > 5) void'(hist0.pop_front());
      if (since >= 4 && hist0.size() == 5)
        chk("d4_vs_d0.shift4", 32'({hs_o[3], vs_o[3], bl[3]}), 32'(hist0[0]));
      chk("d4_vs_d0.frame_count", 32'(fcnt[3]), 32'(fcnt[0]));
      // Full-timing instance.
      chk("def.hcount", 32'(d_hc), 32'(d_h));
      chk("def.vcount", 32'(d_vc), 32'(d_v));
      chk("def.vga_hs", 32'(d_hs), 32'(d_exp_hs));
      chk("def.vga_vs", 32'(d_vs), 32'(d_exp_vs));
      chk("def.blank_n", 32'(d_bl), 32'(d_exp_bl));
      // Aggregates.
      if (!vs_o[1]) begin vs_low1++; vs_run++; end
      else begin if (vs_run > vs_run_max) vs_run_max = vs_run; vs_run = 0; end
      if (bl[1]) blank1++;
      if (!d_hs) begin d_hs_low++; d_hs_run++; end
      else begin if (d_hs_run > d_hs_run_max) d_hs_run_max = d_hs_run; d_hs_run = 0; end
      if (d_ls) begin
        if (!was_rst && d_last_ls >= 0) chk("def.line_period", 32'(cyc - d_last_ls), 32'd800);
        d_last_ls = cyc;
        d_ls_cnt++;
      end
    end
  endtask

  initial begin
    int budget;
    reset_n = 1'b0;
    step(2);
    vs_low1 = 0; blank1 = 0; vs_run = 0; vs_run_max = 0;
    d_hs_low = 0; d_hs_run = 0; d_hs_run_max = 0; d_ls_cnt = 0;
    step(1);
    chk("rst.def.hcount", 32'(d_hc), 32'd0);
    chk("rst.def.vcount", 32'(d_vc), 32'd0);
    chk("rst.def.frame_start", 32'(d_fs), 32'd1);
    chk("rst.def.vga_hs", 32'(d_hs), 32'd1);
    chk("rst.def.vga_vs", 32'(d_vs), 32'd1);
    chk("rst.def.blank_n", 32'(d_bl), 32'd0);
    chk("rst.def.frame_count", 32'(d_fc), 32'd0);
    reset_n = 1'b1;
    step(1);
    chk("rel.def.hcount1", 32'(d_hc), 32'd1);
    step(2 * FR - 2);
    chk("d1.vs_low_total", 32'(vs_low1), 32'(2 * VS * HT));
    chk("d1.vs_run", 32'(vs_run_max), 32'(VS * HT));
    chk("d1.blank_total", 32'(blank1), 32'(2 * HV * VV));
    step(1);
    chk("d1.frame_count2", 32'(fcnt[1]), 32'd2);
    step(1716 - 2 * FR - 1);
    chk("def.hs_low_total", 32'(d_hs_low), 32'd192);
    chk("def.hs_run", 32'(d_hs_run_max), 32'd96);
    chk("def.line_starts", 32'(d_ls_cnt), 32'd3);

    // Reset while inside both sync windows.
    budget = 2 * FR;
    while (!(m_h == HV + HF + 3 && m_v == VV + VF + 1) && budget > 0) begin
      step(1);
      budget--;
    end
    chk("seek.in_time", 32'(budget > 0), 32'd1);
    chk("mid.d3.hs_low_before", 32'(hs_o[2]), 32'd0);
    reset_n = 1'b0;
    step(1);
    chk("mid.d1.hcount", 32'(hc[1]), 32'd0);
    chk("mid.d1.vcount", 32'(vc[1]), 32'd0);
    chk("mid.d1.vga_hs", 32'(hs_o[1]), 32'd1);
    chk("mid.d1.vga_vs", 32'(vs_o[1]), 32'd1);
    chk("mid.d3.vga_hs", 32'(hs_o[2]), 32'd1);
    chk("mid.d3.vga_vs", 32'(vs_o[2]), 32'd1);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("mid.d3.no_stale_hs", 32'(hs_o[2]), 32'd1);
      chk("mid.d3.no_stale_vs", 32'(vs_o[2]), 32'd1);
    end
    step(FR + 20);
    chk("end.d1.frame_count", 32'(fcnt[1]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
